// File: rtl/immed_gen_pipe.sv
// immed_gen_pipe: registered multi-lane immediate generator with a 2-entry skid buffer.
// Each lane decodes instruction bits [31:7] into an XLEN-bit immediate per a 3-bit format
// select; select 3'b111 is illegal and yields imm=0, err=1.
// Optional feature macro: IMMED_GEN_TARGET_EN adds a per-lane pc+imm target adder.
module immed_gen_pipe #(
    parameter int unsigned LANES = 1,
    parameter int unsigned XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*25-1:0]   in_ir,
    input  logic [LANES*3-1:0]    in_sel,
    input  logic [LANES*XLEN-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*XLEN-1:0] out_imm,
    output logic [LANES-1:0]      out_err,
    output logic [LANES*XLEN-1:0] out_target
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StTwo   = 2'd2;

    // ir holds instruction bits [31:7], so instruction bit b lives at ir[b-7].
    function automatic logic [XLEN-1:0] decode(input logic [24:0] ir, input logic [2:0] sel);
        logic [XLEN-1:0] v;
        v = '0;
        case (sel)
            3'b000: v = {{(XLEN-12){ir[24]}}, ir[24:13]};
            3'b001: v = {{(XLEN-12){ir[24]}}, ir[24:18], ir[4:0]};
            3'b010: v = {{(XLEN-12){ir[24]}}, ir[0], ir[23:18], ir[4:1], 1'b0};
            3'b011: v = {{(XLEN-20){ir[24]}}, ir[12:5], ir[13], ir[23:14], 1'b0};
            3'b100: v = {{(XLEN-31){ir[24]}}, ir[23:5], 12'b0};
            3'b101: v = {{(XLEN-5){1'b0}}, ir[12:8]};
            3'b110: begin
                if (XLEN == 64) v = {{(XLEN-6){1'b0}}, ir[18:13]};
                else            v = {{(XLEN-5){1'b0}}, ir[17:13]};
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    logic [LANES*XLEN-1:0] dec_imm;
    logic [LANES-1:0]      dec_err;
    logic [1:0]            state_q, state_d;
    logic                  rdy_q;
    logic                  accept, take;
    logic                  load_main, load_skid, move_skid;
    logic [LANES*XLEN-1:0] main_imm_q, skid_imm_q;
    logic [LANES-1:0]      main_err_q, skid_err_q;

    // Per-lane combinational decode of the offered beat
    always_comb begin
        dec_imm = '0;
        dec_err = '0;
        for (int k = 0; k < LANES; k++) begin
            dec_imm[k*XLEN +: XLEN] = decode(in_ir[k*25 +: 25], in_sel[k*3 +: 3]);
            dec_err[k]              = (in_sel[k*3 +: 3] == 3'b111);
        end
    end

    assign accept    = in_valid & rdy_q;
    assign take      = out_valid & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = (state_q != StEmpty);
    assign out_imm   = main_imm_q;
    assign out_err   = main_err_q;

    // Buffer FSM: flush wins over every other event and suppresses all loads
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StOne;
                        load_main = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && take) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = StTwo;
                        load_skid = 1'b1;
                    end else if (take) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (take) begin
                        state_d   = StOne;
                        move_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    // State and ready flop; a flush forces EMPTY, so ready comes back as 1 afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != StTwo);
        end
    end

    // Main/skid data registers; main holds its value while the buffer is empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_imm_q <= '0;
            main_err_q <= '0;
            skid_imm_q <= '0;
            skid_err_q <= '0;
        end else begin
            if (load_main) begin
                main_imm_q <= dec_imm;
                main_err_q <= dec_err;
            end else if (move_skid) begin
                main_imm_q <= skid_imm_q;
                main_err_q <= skid_err_q;
            end
            if (load_skid) begin
                skid_imm_q <= dec_imm;
                skid_err_q <= dec_err;
            end
        end
    end

`ifdef IMMED_GEN_TARGET_EN
    logic [LANES*XLEN-1:0] dec_tgt, main_tgt_q, skid_tgt_q;

    // Per-lane pc+imm, modulo 2^XLEN; an illegal lane has imm=0 so its target is the pc
    always_comb begin
        dec_tgt = '0;
        for (int k = 0; k < LANES; k++) begin
            dec_tgt[k*XLEN +: XLEN] = in_pc[k*XLEN +: XLEN] + dec_imm[k*XLEN +: XLEN];
        end
    end

    // Target registers follow the same load/move controls as the immediates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_tgt_q <= '0;
            skid_tgt_q <= '0;
        end else begin
            if (load_main)      main_tgt_q <= dec_tgt;
            else if (move_skid) main_tgt_q <= skid_tgt_q;
            if (load_skid)      skid_tgt_q <= dec_tgt;
        end
    end

    assign out_target = main_tgt_q;
`else
    logic unused_pc;
    assign unused_pc  = ^in_pc;
    assign out_target = '0;
`endif

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Scoreboard bench for immed_gen_pipe, LANES=2, XLEN=64.
module tb_immed_gen_pipe;

    localparam int L = 2;
    localparam int X = 64;

    typedef struct packed {
        logic [L*X-1:0] imm;
        logic [L-1:0]   err;
        logic [L*X-1:0] tgt;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [L*25-1:0] in_ir = '0;
    logic [L*3-1:0] in_sel = '0;
    logic [L*X-1:0] in_pc = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [L*X-1:0] out_imm;
    logic [L-1:0]   out_err;
    logic [L*X-1:0] out_target;

    int    checks = 0;
    int    errors = 0;
    beat_t sb_q[$];
    beat_t mon_b;

    immed_gen_pipe #(.LANES(L), .XLEN(X)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .in_sel    (in_sel),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err),
        .out_target(out_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [L*X-1:0] act, input logic [L*X-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one beat from posedge+1 until accepted; push its expectation when acceptance is due
    task automatic send(input logic [31:0] i0, input logic [2:0] s0, input logic [63:0] p0,
                        input logic [31:0] i1, input logic [2:0] s1, input logic [63:0] p1,
                        input logic [63:0] e0, input logic [63:0] e1, input logic [1:0] ee);
        beat_t b;
        int    tries;
        bit    done;
        tries    = 0;
        done     = 1'b0;
        in_ir    = {i1[31:7], i0[31:7]};
        in_sel   = {s1, s0};
        in_pc    = {p1, p0};
        in_valid = 1'b1;
        while (!done) begin
            if (in_ready) begin
                b.imm = {e1, e0};
                b.err = ee;
`ifdef IMMED_GEN_TARGET_EN
                b.tgt = {p1 + e1, p0 + e0};
`else
                b.tgt = '0;
`endif
                sb_q.push_back(b);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                tries++;
                if (tries > 40) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout got no in_ready expected accept within 40 cycles");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Monitor: every beat taken at the next edge is compared with the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat got imm %h expected no beat", out_imm);
            end else begin
                mon_b = sb_q.pop_front();
                chk("beat_imm", out_imm, mon_b.imm);
                chk("beat_err", {{(L*X-L){1'b0}}, out_err}, {{(L*X-L){1'b0}}, mon_b.err});
                chk("beat_tgt", out_target, mon_b.tgt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_valid", {127'b0, out_valid}, 0);
        chk("rst_ready", {127'b0, in_ready}, 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_err", {126'b0, out_err}, 0);
        chk("rst_tgt", out_target, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("rel_ready_low", {127'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        chk("rel_ready_high", {127'b0, in_ready}, 1);

        // Streamed directed vectors, one per cycle with out_ready=1
        send(32'hFFF00093, 3'b000, 64'h200, 32'hFE000EE3, 3'b010, 64'h100,
             64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 2'b00);
        chk("latency_valid", {127'b0, out_valid}, 1);
        send(32'h12345037, 3'b100, 64'h1000, 32'h000FD073, 3'b101, 64'h2000,
             64'h12345000, 64'h1F, 2'b00);
        send(32'h80000037, 3'b100, 64'h10, 32'h12345037, 3'b111, 64'h500,
             64'hFFFFFFFF80000000, 64'h0, 2'b10);
        send(32'h01000093, 3'b000, 64'hFFFFFFFFFFFFFFF0, 32'hFE112E23, 3'b001, 64'h40,
             64'h10, 64'hFFFFFFFFFFFFFFFC, 2'b00);
        send(32'hFFDFF06F, 3'b011, 64'h0, 32'h83F00013, 3'b110, 64'h0,
             64'hFFFFFFFFFFFFFFFC, 64'h3F, 2'b00);
        send(32'hFFFFFFFF, 3'b111, 64'h7, 32'h80008073, 3'b101, 64'h8,
             64'h0, 64'h1, 2'b01);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: A, B fill the buffer, C waits, then drain without gaps
        out_ready = 1'b0;
        send(32'h00100093, 3'b000, 64'h0, 32'h00200093, 3'b000, 64'h0, 64'h1, 64'h2, 2'b00);
        send(32'h00300093, 3'b000, 64'h0, 32'h00400093, 3'b000, 64'h0, 64'h3, 64'h4, 2'b00);
        fork
            send(32'h00500093, 3'b000, 64'h0, 32'h00600093, 3'b000, 64'h0,
                 64'h5, 64'h6, 2'b00);
            begin
                chk("bp_ready_low", {127'b0, in_ready}, 0);
                repeat (2) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_nogap", {127'b0, out_valid}, 1);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Flush in state TWO with a beat offered
        out_ready = 1'b0;
        send(32'h00700093, 3'b000, 64'h0, 32'h00800093, 3'b000, 64'h0, 64'h7, 64'h8, 2'b00);
        send(32'h00900093, 3'b000, 64'h0, 32'h00A00093, 3'b000, 64'h0, 64'h9, 64'hA, 2'b00);
        chk("flush_pre_ready", {127'b0, in_ready}, 0);
        in_ir    = {25'h1, 25'h2};
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        sb_q.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {127'b0, out_valid}, 0);
        chk("flush_ready", {127'b0, in_ready}, 1);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("flush_nobeat", {127'b0, out_valid}, 0);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle in state ONE
        out_ready = 1'b0;
        send(32'h00B00093, 3'b000, 64'h0, 32'h00C00093, 3'b000, 64'h0, 64'hB, 64'hC, 2'b00);
        chk("ar_pre_valid", {127'b0, out_valid}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {127'b0, out_valid}, 0);
        chk("ar_ready", {127'b0, in_ready}, 0);
        chk("ar_imm", out_imm, 0);
        chk("ar_err", {126'b0, out_err}, 0);
        sb_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("ar_rel_ready_low", {127'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        chk("ar_rel_ready_high", {127'b0, in_ready}, 1);
        chk("ar_rel_valid", {127'b0, out_valid}, 0);
        out_ready = 1'b1;

        // One more beat after reset recovery
        send(32'hFFF00093, 3'b000, 64'h0, 32'h000FD073, 3'b101, 64'h0,
             64'hFFFFFFFFFFFFFFFF, 64'h1F, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        chk("end_sb_empty", sb_q.size(), 0);
        chk("end_valid", {127'b0, out_valid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/immed_gen_pipe.md
# immed_gen_pipe

Registered, multi-lane immediate generator for the decode stage of the pipelined core. It decodes `LANES` instruction-word fields per cycle into sign- or zero-extended `XLEN`-bit immediates. It adds CSR-zimm and shift-amount formats and flags illegal selects. A valid/ready interface with a 2-entry skid buffer lets decode stall without dropping words, and an optional PC-relative target adder is included.

## Interface
- `LANES`, 1: instructions decoded per beat (1..4); all lanes move together.
- `XLEN`, 32: output width (32 or 64).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous pipeline flush; discards all buffered beats.
- `in_valid` input 1: a beat is offered.
- `in_ready` output 1: the block accepts a beat this cycle.
- `in_ir` input `LANES*25`: per lane, instruction bits [31:7]; lane k is at [25k+24:25k].
- `in_sel` input `LANES*3`: per-lane format select.
- `in_pc` input `LANES*XLEN`: per-lane PC, used only with the target feature.
- `out_valid` output 1: an output beat is held.
- `out_ready` input 1: the consumer takes the beat.
- `out_imm` output `LANES*XLEN`: per-lane immediates.
- `out_err` output `LANES`: per-lane illegal-select flag.
- `out_target` output `LANES*XLEN`: per-lane `pc + imm`.

## Operation
- Formats are selected by sel. Bit positions refer to the instruction word; sext/zext means sign- or zero-extend to `XLEN`.
  - 000 I: sext [31:20].
  - 001 S: sext {[31:25],[11:7]}.
  - 010 B: sext {[31],[7],[30:25],[11:8],0}.
  - 011 J: sext {[31],[19:12],[20],[30:21],0}.
  - 100 U: sext {[31:12],12'b0}. When XLEN=64, the upper 32 bits copy bit 31.
  - 101 Z: zext [19:15] (CSR uimm).
  - 110 SH: zext [24:20] when XLEN=32; zext [25:20] when XLEN=64.
  - 111: imm=0 and err=1.
- Decode is combinational on the inputs. Results are captured into the main or skid register on acceptance.
- The buffer is a state machine over the main and skid registers.
  - States: EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY + accept → ONE.
  - ONE + accept + take → ONE, with main reloaded.
  - ONE + accept, no take → TWO, with the new beat in skid.
  - ONE + take, no accept → EMPTY.
  - TWO + take → ONE, with skid moved to main. No accept is possible in TWO.
- Accept = `in_valid & in_ready`. Take = `out_valid & out_ready`.
- `out_valid` = state != EMPTY. Outputs always come from the main register, in FIFO order.
- `in_ready` is a flop.
  - Reset value 0.
  - Goes to 1 on the first edge after `rst_n` rises.
  - Afterwards equals (next state != TWO).
- `flush` has priority over every other event. On the next edge the state is EMPTY and the simultaneous input beat is dropped. `in_ready` is forced to 1 after the flush edge, except during reset.
- Outputs with `out_valid`=0 hold their last value. Only the valid bit is meaningful.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Sustained throughput is 1 beat/cycle while `out_ready`=1.
- `out_ready` may drop at any time. At most 2 beats are held, and no beat is lost or duplicated.
- Holding `in_valid` with `in_ready`=0 has no effect. The data need not be stable.
- Reset is asynchronous and may occur mid-operation.
  - State → EMPTY; `out_valid`=0, `in_ready`=0.
  - `out_imm`, `out_err` and `out_target` → 0.
  - The buffered contents are discarded.
- Width rules:
  - The target is computed modulo 2^`XLEN`; wrap-around is silent.
  - Z and SH are never sign-extended.

## Configuration
- `IMMED_GEN_TARGET_EN` defined: one `XLEN` adder per lane computes `in_pc + imm` at accept time and registers it alongside the immediate.
  - When err=1, the target equals the pc.
- `IMMED_GEN_TARGET_EN` undefined: no adders are built, `out_target` is tied to 0, and `in_pc` is ignored.

## Test plan
- I-type, XLEN=64: ir from 0xFFF00093, sel 000 → `out_imm` 0xFFFFFFFFFFFFFFFF, err 0, one cycle after accept.
- B-type with target enabled: ir from 0xFE000EE3, sel 010, pc 0x100 → imm 0xFFFFFFFC, target 0x000000FC.
- LANES=2: lane0 U from 0x12345037 (sel 100), lane1 Z from 0x000FD073 (sel 101) → imm0 0x12345000, imm1 0x0000001F. Also sel 111 on lane1 → imm1 0, err 0b10.
- Backpressure: offer beats A, B, C back-to-back with `out_ready`=0.
  - A and B are accepted; `in_ready` is 0 in the cycle C is offered.
  - Then raise `out_ready` → outputs A, B, C in order with no gaps after C is accepted.
- Flush: state TWO and `in_valid`=1 with `flush`=1 → next cycle `out_valid`=0, `in_ready`=1, and no beat appears later.
- Async reset: pulse `rst_n` low mid-cycle in state ONE → `out_valid` drops immediately; `in_ready` is 0 until the first edge after release.
